// File: rtl/calc_g_pkg.sv
// Shared constants and scan state encoding for the calc_G_top input sequencer.
package calc_g_pkg;

  localparam int MN_W_DEF  = 10;
  localparam int ZP_W_DEF  = 32;
  localparam int G_LAT_DEF = 8;
  localparam int M_MAX_DEF = 255;
  localparam int N_MAX_DEF = 255;
  localparam int PT_CNT_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/calc_g_valid_dly.sv
// DEPTH-stage shift register with synchronous clear, used to align sideband
// flags (valid/last) with a fixed-latency datapath that has no enable.
module calc_g_valid_dly #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/calc_g_mn_scan.sv
// Raster-scan sequencer feeding signed (m,n) points and zparam into calc_G_top.
// Optional point counter enabled by defining CALC_G_SCAN_COUNT_EN.
module calc_g_mn_scan
  import calc_g_pkg::*;
#(
  parameter int MN_W  = MN_W_DEF,
  parameter int ZP_W  = ZP_W_DEF,
  parameter int M_MAX = M_MAX_DEF,
  parameter int N_MAX = N_MAX_DEF,
  parameter int G_LAT = G_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MN_W-2:0]        m_lim,
  input  logic [MN_W-2:0]        n_lim,
  input  logic [ZP_W-1:0]        zparam_in,
  input  logic                   hold,
  output logic signed [MN_W-1:0] m,
  output logic signed [MN_W-1:0] n,
  output logic [ZP_W-1:0]        zparam,
  output logic                   mn_valid,
  output logic                   g_valid,
  output logic                   g_last,
  output logic                   busy,
  output logic                   done,
  output logic [PT_CNT_W-1:0]    pt_cnt
);

  localparam int LW = MN_W - 1;
  localparam logic [LW-1:0] M_MAX_C = LW'(M_MAX);
  localparam logic [LW-1:0] N_MAX_C = LW'(N_MAX);

  scan_state_e            state_q, state_d;
  logic signed [MN_W-1:0] m_q, m_d, n_q, n_d;
  logic signed [MN_W-1:0] ml_q, ml_d, nl_q, nl_d;
  logic [ZP_W-1:0]        zp_q, zp_d;
  logic                   done_q, done_d;
  logic [LW-1:0]          m_clamp, n_clamp;
  logic                   start_acc, scan_fire, scan_last;
  logic                   g_valid_w, g_last_w;

  always_comb begin
    m_clamp   = (m_lim > M_MAX_C) ? M_MAX_C : m_lim;
    n_clamp   = (n_lim > N_MAX_C) ? N_MAX_C : n_lim;
    // The done cycle already shows IDLE, but a start landing on it is dropped.
    start_acc = (state_q == ST_IDLE) && start && !done_q;
    scan_fire = (state_q == ST_SCAN) && !hold;
    scan_last = scan_fire && (m_q == ml_q) && (n_q == nl_q);

    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    ml_d    = ml_q;
    nl_d    = nl_q;
    zp_d    = zp_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          ml_d    = $signed({1'b0, m_clamp});
          nl_d    = $signed({1'b0, n_clamp});
          m_d     = -$signed({1'b0, m_clamp});
          n_d     = -$signed({1'b0, n_clamp});
          zp_d    = zparam_in;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          // Indices stay on the final point so +Ml never steps past the range.
          state_d = ST_DRAIN;
        end else if (scan_fire) begin
          if (n_q != nl_q) begin
            n_d = n_q + MN_W'(1);
          end else begin
            n_d = -nl_q;
            m_d = m_q + MN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The delay line itself measures the G_LAT drain time.
        if (g_last_w) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      ml_q    <= '0;
      nl_q    <= '0;
      zp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      ml_q    <= ml_d;
      nl_q    <= nl_d;
      zp_q    <= zp_d;
      done_q  <= done_d;
    end
  end

  calc_g_valid_dly #(
    .DEPTH (G_LAT),
    .WIDTH (2)
  ) u_valid_dly (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({scan_fire, scan_last}),
    .dout_o ({g_valid_w, g_last_w})
  );

`ifdef CALC_G_SCAN_COUNT_EN
  logic [PT_CNT_W-1:0] pt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)            pt_cnt_q <= '0;
    else if (start_acc) pt_cnt_q <= '0;
    else if (scan_fire) pt_cnt_q <= pt_cnt_q + PT_CNT_W'(1);
  end

  assign pt_cnt = pt_cnt_q;
`else
  assign pt_cnt = '0;
`endif

  assign m        = m_q;
  assign n        = n_q;
  assign zparam   = zp_q;
  assign mn_valid = scan_fire;
  assign g_valid  = g_valid_w;
  assign g_last   = g_last_w;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_calc_g_mn_scan.sv
// Self-checking bench for calc_g_mn_scan against a point-list / schedule model.
module tb_calc_g_mn_scan;

  localparam int MN_W   = 10;
  localparam int ZP_W   = 32;
  localparam int M_MAX  = 255;
  localparam int N_MAX  = 255;
  localparam int G_LAT  = 8;
  localparam int BUDGET = 12000;
  localparam int ARR_N  = BUDGET + G_LAT + 8;

  logic                   clk = 1'b0;
  logic                   rst, start, hold;
  logic [MN_W-2:0]        m_lim, n_lim;
  logic [ZP_W-1:0]        zparam_in;
  logic signed [MN_W-1:0] m, n;
  logic [ZP_W-1:0]        zparam;
  logic                   mn_valid, g_valid, g_last, busy, done;
  logic [19:0]            pt_cnt;

  int total = 0;
  int bad   = 0;
  bit exp_gv [ARR_N];
  bit exp_gl [ARR_N];

  calc_g_mn_scan #(
    .MN_W(MN_W), .ZP_W(ZP_W), .M_MAX(M_MAX), .N_MAX(N_MAX), .G_LAT(G_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .m_lim(m_lim), .n_lim(n_lim),
    .zparam_in(zparam_in), .hold(hold), .m(m), .n(n), .zparam(zparam),
    .mn_valid(mn_valid), .g_valid(g_valid), .g_last(g_last), .busy(busy),
    .done(done), .pt_cnt(pt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_all_zero(input string tag);
    total++; if (m !== '0)        begin bad++; $display("FAIL %s m got=%0d want=0", tag, m); end
    total++; if (n !== '0)        begin bad++; $display("FAIL %s n got=%0d want=0", tag, n); end
    total++; if (zparam !== '0)   begin bad++; $display("FAIL %s zparam got=%h want=0", tag, zparam); end
    total++; if (mn_valid !== 1'b0) begin bad++; $display("FAIL %s mn_valid got=%b want=0", tag, mn_valid); end
    total++; if (g_valid !== 1'b0)  begin bad++; $display("FAIL %s g_valid got=%b want=0", tag, g_valid); end
    total++; if (g_last !== 1'b0)   begin bad++; $display("FAIL %s g_last got=%b want=0", tag, g_last); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL %s busy got=%b want=0", tag, busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL %s done got=%b want=0", tag, done); end
    total++; if (pt_cnt !== '0)     begin bad++; $display("FAIL %s pt_cnt got=%0d want=0", tag, pt_cnt); end
  endtask

  // hold_mode: 0 none, 1 hold during scan cycles [ha,hb], 2 random.
  // restart_k: cycle at which an extra start is pulsed (0 = never).
  task automatic run_scan(input string name, input int mlim, input int nlim,
                          input logic [31:0] zp, input int hold_mode,
                          input int ha, input int hb, input int restart_k);
    int qm[$];
    int qn[$];
    int ml, nl, exp_total, last_k, k;
    logic hv;
    logic [19:0] exp_cnt;
    ml = (mlim > M_MAX) ? M_MAX : mlim;
    nl = (nlim > N_MAX) ? N_MAX : nlim;
    for (int a = -ml; a <= ml; a++)
      for (int b = -nl; b <= nl; b++) begin
        qm.push_back(a);
        qn.push_back(b);
      end
    exp_total = qm.size();
    for (int i = 0; i < ARR_N; i++) begin exp_gv[i] = 1'b0; exp_gl[i] = 1'b0; end
`ifdef CALC_G_SCAN_COUNT_EN
    exp_cnt = 20'(exp_total);
`else
    exp_cnt = '0;
`endif

    @(posedge clk); #1;
    start = 1'b1; hold = 1'b0;
    m_lim = (MN_W-1)'(mlim); n_lim = (MN_W-1)'(nlim); zparam_in = zp;
    last_k = BUDGET;
    k = 1;
    while (k <= last_k + 2 && k < BUDGET) begin
      @(posedge clk); #1;
      start = (k == restart_k) || (k == last_k + 1);
      if (start) begin
        m_lim = (MN_W-1)'($urandom); n_lim = (MN_W-1)'($urandom); zparam_in = $urandom;
      end
      case (hold_mode)
        0:       hv = 1'b0;
        1:       hv = (k >= ha) && (k <= hb);
        default: hv = ($urandom_range(3) == 0);
      endcase
      hold = hv;
      @(negedge clk);
      if (qm.size() > 0) begin
        total++;
        if (mn_valid !== !hv) begin bad++; $display("FAIL %s mn_valid k=%0d got=%b want=%b", name, k, mn_valid, !hv); end
        total++;
        if (m !== MN_W'(qm[0]) || n !== MN_W'(qn[0])) begin
          bad++; $display("FAIL %s point k=%0d got=(%0d,%0d) want=(%0d,%0d)", name, k, m, n, qm[0], qn[0]);
        end
        if (!hv) begin
          void'(qm.pop_front());
          void'(qn.pop_front());
          exp_gv[k + G_LAT] = 1'b1;
          if (qm.size() == 0) begin
            exp_gl[k + G_LAT] = 1'b1;
            last_k = k + G_LAT;
          end
        end
      end else begin
        total++;
        if (mn_valid !== 1'b0) begin bad++; $display("FAIL %s mn_valid_drain k=%0d got=%b want=0", name, k, mn_valid); end
      end
      total++;
      if (g_valid !== exp_gv[k]) begin bad++; $display("FAIL %s g_valid k=%0d got=%b want=%b", name, k, g_valid, exp_gv[k]); end
      total++;
      if (g_last !== exp_gl[k]) begin bad++; $display("FAIL %s g_last k=%0d got=%b want=%b", name, k, g_last, exp_gl[k]); end
      total++;
      if (zparam !== zp) begin bad++; $display("FAIL %s zparam k=%0d got=%h want=%h", name, k, zparam, zp); end
      total++;
      if (busy !== (k <= last_k)) begin bad++; $display("FAIL %s busy k=%0d got=%b want=%b", name, k, busy, (k <= last_k)); end
      total++;
      if (done !== (k == last_k + 1)) begin bad++; $display("FAIL %s done k=%0d got=%b want=%b", name, k, done, (k == last_k + 1)); end
      if (k == 1) begin
        total++;
        if (pt_cnt !== '0) begin bad++; $display("FAIL %s pt_cnt_clear got=%0d want=0", name, pt_cnt); end
      end
      k++;
    end
    if (k >= BUDGET) begin
      total++; bad++;
      $display("FAIL %s timeout got=%0d cycles want<%0d", name, k, BUDGET);
    end
    total++;
    if (pt_cnt !== exp_cnt) begin bad++; $display("FAIL %s pt_cnt got=%0d want=%0d", name, pt_cnt, exp_cnt); end
    start = 1'b0; hold = 1'b0;
    $display("scan %s: m_lim=%0d n_lim=%0d points=%0d cycles=%0d", name, mlim, nlim, exp_total, k - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    m_lim = '0; n_lim = '0; zparam_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    run_scan("basic_1x1", 1, 1, 32'h12345678, 0, 0, 0, 0);
  endtask

  task automatic test_single_point();
    run_scan("single_0x0", 0, 0, 32'hCAFEF00D, 0, 0, 0, 0);
  endtask

  task automatic test_clamp();
    run_scan("clamp_400x3", 400, 3, 32'h0BADBEEF, 0, 0, 0, 0);
  endtask

  task automatic test_hold();
    run_scan("hold_3_5", 1, 1, 32'h55AA55AA, 1, 3, 5, 0);
  endtask

  task automatic test_restart_ignored();
    run_scan("restart_mid", 1, 1, 32'hA5A5F0F0, 0, 0, 0, 4);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++)
      run_scan("random", $urandom_range(6), $urandom_range(6), $urandom, 2, 0, 0,
               $urandom_range(8));
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; m_lim = 9'd2; n_lim = 9'd2; zparam_in = 32'hDEADBEEF;
    @(posedge clk); #1 start = 1'b0;
    repeat (G_LAT + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid");
    for (int i = 0; i < G_LAT + 3; i++) begin
      @(negedge clk);
      total++;
      if (g_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL reset_mid_after cyc=%0d got=gv%b/done%b/busy%b want=0/0/0", i, g_valid, done, busy);
      end
    end
    $display("reset_mid: scan aborted");
    run_scan("after_reset", 2, 1, 32'h13579BDF, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_scan("b2b_a", 1, 2, 32'h00000001, 0, 0, 0, 0);
    run_scan("b2b_b", 2, 0, 32'hFFFFFFFE, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_point();
    test_clamp();
    test_hold();
    test_restart_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
